// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes, ALU-decoder codes,
// state encoding and the per-state Moore control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne_sel;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       instr_done;
    } ctrl_t;

    // Opcode-independent controls of each state; DECODE's illegal/instr_done depend on op
    // and are produced outside this table.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
                c.pcsrc   = 2'b00;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg   = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.iord       = 1'b1;
                c.memwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b00;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            BEQEX, BNEEX: begin
                c.alusrca    = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
                c.bne_sel    = (s == BNEEX);
                c.instr_done = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            JEX: begin
                c.pcsrc      = 2'b10;
                c.pcwrite    = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_main_fsm.sv
// Multicycle MIPS main controller: Moore FSM FETCH->DECODE->execute, 2 to 5 cycles per instruction.
// Controls are registered alongside the state; pcen (zero) and DECODE's illegal (op) are combinational.
module mips_main_fsm
    import mips_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_dbg
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   op_legal;
    logic   decode_illegal;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_BNE:  op_legal = SUPPORT_BNE;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_BNE:       nxt = SUPPORT_BNE ? BNEEX : FETCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // The control word is loaded with the state it belongs to, so it is always in step with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            ctrl_q <= state_ctrl(FETCH);
        end else begin
            state  <= nxt;
            ctrl_q <= state_ctrl(nxt);
        end
    end

    assign decode_illegal = (state == DECODE) && !op_legal;

    // Reset blanks every output in the same cycle, so an abandoned store or writeback cannot leak out.
    assign pcen       = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ ctrl_q.bne_sel)));
    assign memwrite   = ~reset & ctrl_q.memwrite;
    assign irwrite    = ~reset & ctrl_q.irwrite;
    assign regwrite   = ~reset & ctrl_q.regwrite;
    assign iord       = ~reset & ctrl_q.iord;
    assign regdst     = ~reset & ctrl_q.regdst;
    assign memtoreg   = ~reset & ctrl_q.memtoreg;
    assign alusrca    = ~reset & ctrl_q.alusrca;
    assign alusrcb    = reset ? 2'b00 : ctrl_q.alusrcb;
    assign pcsrc      = reset ? 2'b00 : ctrl_q.pcsrc;
    assign aluop      = reset ? ALUOP_ADD : ctrl_q.aluop;
    assign illegal    = ~reset & decode_illegal;
    assign instr_done = ~reset & (ctrl_q.instr_done | decode_illegal);
    assign state_dbg  = reset ? 4'(FETCH) : 4'(state);

endmodule

// File: tb/tb_mips_main_fsm.sv
// Self-checking bench for mips_main_fsm: table of whole-instruction summaries, reset corner
// cases, and random instruction streams checked cycle by cycle against a cycle-index model.
module tb_mips_main_fsm;

    localparam bit SUP_BNE = 1'b1;

    localparam logic [5:0] C_RTYPE = 6'b000000;
    localparam logic [5:0] C_LW    = 6'b100011;
    localparam logic [5:0] C_SW    = 6'b101011;
    localparam logic [5:0] C_BEQ   = 6'b000100;
    localparam logic [5:0] C_BNE   = 6'b000101;
    localparam logic [5:0] C_ADDI  = 6'b001000;
    localparam logic [5:0] C_J     = 6'b000010;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       illegal;
        logic       instr_done;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         len;
        logic       pcen_last;
        int         ill;
        int         rw;
        int         mw;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal, instr_done;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mips_main_fsm #(.SUPPORT_BNE(SUP_BNE)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal    (illegal),
        .instr_done (instr_done),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t s;
        s = '{pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca,
              alusrcb, pcsrc, aluop, illegal, instr_done};
        return s;
    endfunction

    function automatic int instr_len(logic [5:0] o);
        case (o)
            C_LW:                   return 5;
            C_SW, C_RTYPE, C_ADDI:  return 4;
            C_BEQ, C_J:             return 3;
            C_BNE:                  return SUP_BNE ? 3 : 2;
            default:                return 2;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of an instruction with opcode o.
    function automatic obs_t model(logic [5:0] o, int k, logic z);
        obs_t e;
        int   n;
        e = '0;
        n = instr_len(o);
        if (k == 0) begin
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
            e.alusrcb = 2'b01;
        end else if (k == 1) begin
            e.alusrcb = 2'b11;
            if (n == 2) begin
                e.illegal    = 1'b1;
                e.instr_done = 1'b1;
            end
        end else begin
            e.instr_done = (k == n - 1);
            case (o)
                C_LW, C_SW: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else if (k == 3) begin
                        e.iord     = 1'b1;
                        e.memwrite = (o == C_SW);
                    end else begin
                        e.memtoreg = 1'b1;
                        e.regwrite = 1'b1;
                    end
                end
                C_RTYPE: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1;
                        e.aluop   = 2'b10;
                    end else begin
                        e.regdst   = 1'b1;
                        e.regwrite = 1'b1;
                    end
                end
                C_ADDI: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else begin
                        e.regwrite = 1'b1;
                    end
                end
                C_BEQ, C_BNE: begin
                    e.alusrca = 1'b1;
                    e.aluop   = 2'b01;
                    e.pcsrc   = 2'b01;
                    e.pcen    = (o == C_BEQ) ? z : ~z;
                end
                C_J: begin
                    e.pcsrc = 2'b10;
                    e.pcen  = 1'b1;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the following FETCH.
    task automatic run_model(input logic [5:0] o, input string tag);
        int n;
        n  = instr_len(o);
        op = o;
        for (int k = 0; k < n; k++) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("%s op=%b cyc%0d", tag, o, k), sample(), model(o, k, zero));
            if (k == 0) check_val($sformatf("%s fetch_state", tag), int'(state_dbg), 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_table(input vec_t v, input int idx);
        int   cycles, rw, mw, ill;
        logic pl, done;
        cycles = 0; rw = 0; mw = 0; ill = 0; pl = 1'b0; done = 1'b0;
        op   = v.op;
        zero = v.zero;
        while (!done && cycles < 10) begin
            @(negedge clk);
            cycles++;
            rw  += int'(regwrite);
            mw  += int'(memwrite);
            ill += int'(illegal);
            if (instr_done) begin
                done = 1'b1;
                pl   = pcen;
            end
            @(posedge clk);
            #1;
        end
        check_val($sformatf("tbl%0d op=%b cycles", idx, v.op), cycles, v.len);
        check_val($sformatf("tbl%0d op=%b pcen_last", idx, v.op), int'(pl), int'(v.pcen_last));
        check_val($sformatf("tbl%0d op=%b illegal_cnt", idx, v.op), ill, v.ill);
        check_val($sformatf("tbl%0d op=%b regwrite_cnt", idx, v.op), rw, v.rw);
        check_val($sformatf("tbl%0d op=%b memwrite_cnt", idx, v.op), mw, v.mw);
    endtask

    vec_t tbl[11];

    initial begin
        logic [5:0] legal_ops[7];
        logic [5:0] ro;

        tbl[0]  = '{C_LW,      1'b0, 5, 1'b0, 0, 1, 0};
        tbl[1]  = '{C_SW,      1'b1, 4, 1'b0, 0, 0, 1};
        tbl[2]  = '{C_RTYPE,   1'b0, 4, 1'b0, 0, 1, 0};
        tbl[3]  = '{C_ADDI,    1'b1, 4, 1'b0, 0, 1, 0};
        tbl[4]  = '{C_BEQ,     1'b1, 3, 1'b1, 0, 0, 0};
        tbl[5]  = '{C_BEQ,     1'b0, 3, 1'b0, 0, 0, 0};
        tbl[6]  = '{C_BNE,     1'b0, 3, 1'b1, 0, 0, 0};
        tbl[7]  = '{C_BNE,     1'b1, 3, 1'b0, 0, 0, 0};
        tbl[8]  = '{C_J,       1'b0, 3, 1'b1, 0, 0, 0};
        tbl[9]  = '{6'b111111, 1'b1, 2, 1'b0, 1, 0, 0};
        tbl[10] = '{6'b000001, 1'b0, 2, 1'b0, 1, 0, 0};

        legal_ops = '{C_RTYPE, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_J};

        reset = 1'b1;
        op    = C_LW;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", sample(), '0);
        check_val("reset state_dbg", int'(state_dbg), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_model(C_LW, "post_reset");

        for (int i = 0; i < 11; i++) run_table(tbl[i], i);

        // Reset asserted in the store cycle of sw: the store is abandoned, FSM restarts at FETCH.
        op = C_SW;
        for (int k = 0; k < 3; k++) begin
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("sw_pre cyc%0d", k), sample(), model(C_SW, k, zero));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("sw memwr cycle", sample(), model(C_SW, 3, zero));
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sw after reset outputs", sample(), '0);
        check_val("sw after reset state_dbg", int'(state_dbg), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_model(C_RTYPE, "restart");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) ro = 6'($urandom_range(0, 63));
            else ro = legal_ops[$urandom_range(0, 6)];
            run_model(ro, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
